// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master: FSM encoding, default
// widths and the timeout counter width.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int unsigned WB_DATA_WIDTH   = 32;
  localparam int unsigned WB_ADDR_WIDTH   = 32;
  localparam int unsigned WB_TMO_CNT_W    = 16;
  localparam int unsigned WB_TMO_DEFAULT  = 255;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count would reach LIMIT.
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int unsigned LIMIT = WB_TMO_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WB_TMO_CNT_W-1:0] LAST = WB_TMO_CNT_W'(LIMIT - 1);

  logic [WB_TMO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged one count early so the abort edge is the LIMIT-th idle cycle.
  assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-access initiator: valid/ready command in, one bus
// cycle, valid/ready response out. Optional watchdog: WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = WB_TMO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [DATA_WIDTH-1:0]   cmd_dat,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic                    we_o,
  output logic [SELECT_WIDTH-1:0] sel_o,
  output logic                    stb_o,
  output logic                    cyc_o,
  input  logic                    ack_i,
  input  logic                    err_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES out of range 1..65535");
  end

  wb_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
  logic [DATA_WIDTH-1:0]     dat_q, dat_d;
  logic [SELECT_WIDTH-1:0]   sel_q, sel_d;
  logic                      we_q, we_d;
  logic [DATA_WIDTH-1:0]     rsp_dat_q, rsp_dat_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      tmo_expired;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  wb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ST_BUS),
    .en      ((state_q == ST_BUS) && !ack_i && !err_i),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          we_d    = cmd_we;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // err_i outranks ack_i; a real ack outranks a same-edge watchdog expiry.
        if (err_i) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          state_d   = ST_RESP;
        end else if (ack_i) begin
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? '0 : dat_i;
          state_d   = ST_RESP;
        end else if (tmo_expired) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign cyc_o     = (state_q == ST_BUS);
  assign stb_o     = (state_q == ST_BUS);
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign sel_o     = sel_q;
  assign we_o      = we_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master against a 16-word Wishbone RAM that acks one
// cycle after strobe; responses are checked against a scoreboard queue.
module tb_wb_cmd_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [SW-1:0] cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o, dat_i;
  logic          we_o, stb_o, cyc_o, ack_i, err_i;
  logic [SW-1:0] sel_o;

  wb_cmd_master #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .SELECT_WIDTH   (SW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .dat_i     (dat_i),
    .we_o      (we_o),
    .sel_o     (sel_o),
    .stb_o     (stb_o),
    .cyc_o     (cyc_o),
    .ack_i     (ack_i),
    .err_i     (err_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave: 16-word RAM, registered ack one cycle after strobe
  logic [DW-1:0] ram [16];
  logic          ack_q = 1'b0;
  logic [DW-1:0] rd_q = '0;
  logic          ack_en = 1'b1;
  logic          err_mode = 1'b0;

  initial for (int i = 0; i < 16; i++) ram[i] = '0;

  always @(posedge clk) begin
    if (cyc_o && stb_o && ack_en && !ack_q) begin
      ack_q <= 1'b1;
      rd_q  <= ram[adr_o[5:2]];
      if (we_o) begin
        for (int b = 0; b < SW; b++)
          if (sel_o[b]) ram[adr_o[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  assign ack_i = ack_q;
  assign err_i = ack_q & err_mode;
  assign dat_i = rd_q;

  // Bench-side reference memory and scoreboard
  logic [DW-1:0] model [16];
  initial for (int i = 0; i < 16; i++) model[i] = '0;
  rsp_t          exp_q[$];

  int            cyc_cnt = 0;
  int            stb_total = 0;
  int            acc_cyc = 0;
  logic [AW-1:0] cur_adr;
  logic [DW-1:0] cur_dat;
  logic [SW-1:0] cur_sel;
  logic          cur_we;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (stb_o) begin
      stb_total <= stb_total + 1;
      chk("bus_adr", 64'(adr_o), 64'(cur_adr));
      chk("bus_we",  64'(we_o),  64'(cur_we));
      chk("bus_sel", 64'(sel_o), 64'(cur_sel));
      if (cur_we) chk("bus_dat", 64'(dat_o), 64'(cur_dat));
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(1), 64'(0));
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_dat", 64'(rsp_dat), 64'(e.dat));
      end
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel, input logic push, input logic tmo_err);
    rsp_t e;
    @(posedge clk); #1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    if (err_mode || tmo_err) begin
      e.err = 1'b1; e.dat = '0;
    end else if (we) begin
      for (int b = 0; b < SW; b++)
        if (sel[b]) model[adr[5:2]][8*b +: 8] = dat[8*b +: 8];
      e.err = 1'b0; e.dat = '0;
    end else begin
      e.err = 1'b0; e.dat = model[adr[5:2]];
    end
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc_cnt;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin
        lat = cyc_cnt - acc_cyc;
        break;
      end
    end
  endtask

  task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
    int lat;
    int base;
    base = stb_total;
    issue(we, adr, dat, sel, 1'b1, 1'b0);
    base = stb_total;
    wait_rsp(lat);
    chk("rsp_latency", 64'(lat), 64'(2));
    chk("stb_cycles", 64'(stb_total - base), 64'(2));
  endtask

  initial begin
    int   lat;
    int   base;
    logic [DW-1:0] held;
    logic seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1;
    cur_we = 1'b0; cur_adr = '0; cur_dat = '0; cur_sel = '0;
    #3;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
    chk("rst_rsp_dat",   64'(rsp_dat),   64'(0));
    chk("rst_cyc",       64'(cyc_o),     64'(0));
    chk("rst_stb",       64'(stb_o),     64'(0));
    chk("rst_we",        64'(we_o),      64'(0));
    chk("rst_adr",       64'(adr_o),     64'(0));
    chk("rst_dat",       64'(dat_o),     64'(0));
    chk("rst_sel",       64'(sel_o),     64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Write/read round trip, byte-lane merge, and a few patterned words
    run_cmd(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
    run_cmd(1'b0, 32'h8, 32'h0, 4'hF);
    run_cmd(1'b1, 32'h8, 32'h0000AA00, 4'b0010);
    run_cmd(1'b0, 32'h8, 32'h0, 4'hF);
    run_cmd(1'b1, 32'h3C, 32'h12345678, 4'b1001);
    run_cmd(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
    run_cmd(1'b0, 32'h3C, 32'h0, 4'hF);
    run_cmd(1'b0, 32'h0, 32'h0, 4'hF);
    run_cmd(1'b0, 32'h4, 32'h0, 4'hF);

    // Simultaneous err_i and ack_i on a read
    err_mode = 1'b1;
    run_cmd(1'b0, 32'h8, 32'h0, 4'hF);
    chk("err_cyc_low", 64'(cyc_o), 64'(0));
    @(posedge clk); #1 err_mode = 1'b0;

    // Response back-pressure
    rsp_ready = 1'b0;
    run_cmd(1'b0, 32'h3C, 32'h0, 4'hF);
    held = rsp_dat;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid), 64'(1));
      chk("stall_dat",   64'(rsp_dat),   64'(held));
      chk("stall_ready", 64'(cmd_ready), 64'(0));
      chk("stall_cyc",   64'(cyc_o),     64'(0));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;

    // Unresponsive slave
    ack_en = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b1);
    base = stb_total;
    wait_rsp(lat);
    chk("tmo_latency", 64'(lat), 64'(4));
    chk("tmo_stb_cycles", 64'(stb_total - base), 64'(4));
    issue(1'b0, 32'h14, 32'h0, 4'hF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
`else
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0);
    base = stb_total;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    #1;
    chk("hang_stb_cycles", 64'(stb_total - base), 64'(1000));
    chk("hang_no_rsp", 64'(seen), 64'(0));
`endif

    // Asynchronous reset mid-access
    #2 rst = 1'b1;
    #1;
    chk("midrst_cyc",       64'(cyc_o),     64'(0));
    chk("midrst_stb",       64'(stb_o),     64'(0));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    ack_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("midrst_no_rsp", 64'(seen), 64'(0));
    run_cmd(1'b0, 32'h8, 32'h0, 4'hF);
    run_cmd(1'b1, 32'h20, 32'hCAFEF00D, 4'b0100);
    run_cmd(1'b0, 32'h20, 32'h0, 4'hF);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-access initiator driving the slave side of the SoC's on-chip memories and peripherals. Converts a valid/ready command stream (one read or write per command) into a single Wishbone cycle, then returns data and status on a valid/ready response stream. Sits between the CPU or DMA request logic and the Wishbone interconnect, one transaction outstanding at a time.

## Interface
- DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64)
- ADDR_WIDTH, 32, address bus width in bits
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width
- TIMEOUT_CYCLES, 255, bus cycles waited for ack_i/err_i before abort (used only with timeout compiled in; legal range 1..65535)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both high
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  ADDR_WIDTH  byte address
- cmd_dat  in  DATA_WIDTH  write data
- cmd_sel  in  SELECT_WIDTH  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_dat  out  DATA_WIDTH  read data; zero for writes and errors
- rsp_err  out  1  bus error or timeout
- adr_o  out  ADDR_WIDTH  Wishbone ADR_O
- dat_o  out  DATA_WIDTH  Wishbone DAT_O
- dat_i  in  DATA_WIDTH  Wishbone DAT_I
- we_o  out  1  Wishbone WE_O
- sel_o  out  SELECT_WIDTH  Wishbone SEL_O
- stb_o  out  1  Wishbone STB_O
- cyc_o  out  1  Wishbone CYC_O
- ack_i  in  1  Wishbone ACK_I
- err_i  in  1  Wishbone ERR_I

## Operation
- FSM states: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: cmd_ready = 1. On cmd_valid: register cmd_adr/dat/sel/we onto adr_o/dat_o/sel_o/we_o, assert cyc_o and stb_o, go BUS, clear timeout counter.
- BUS: cmd_ready = 0; cyc_o = stb_o = 1; bus outputs held stable. On edge with err_i = 1: rsp_err = 1, rsp_dat = 0. Else on ack_i = 1: rsp_err = 0, rsp_dat = dat_i if read else 0. Either case: drop cyc_o/stb_o, go RESP.
- ack_i and err_i both high: error wins.
- RESP: rsp_valid = 1, rsp_dat/rsp_err stable, cyc_o = stb_o = 0. On rsp_ready go IDLE. No new command accepted in RESP (cmd_ready = 0).
- ack_i/err_i while in IDLE or RESP are ignored.
- dat_o/adr_o/sel_o/we_o retain last values outside BUS (no zeroing required); verification must only check them while stb_o = 1.

## Timing
- Reset (async assert): cmd_ready = 0 while rst high, then 1; rsp_valid = 0, rsp_err = 0, rsp_dat = 0, cyc_o = stb_o = we_o = 0, adr_o/dat_o/sel_o = 0. Reset mid-cycle drops cyc_o/stb_o immediately, no response produced.
- Command accepted at edge N -> stb_o high from cycle N+1.
- ack_i sampled high at edge M -> stb_o low and rsp_valid high from cycle M+1.
- Against a slave registering ack one cycle after stb: accept at edge 0, rsp_valid in cycle 3; stb_o high exactly 2 cycles, so slave sees only one strobed access.
- Back-to-back throughput: one transaction per 4 cycles with rsp_ready tied high (RESP always lasts >=1 cycle).

## Configuration
- WB_CMD_MASTER_TIMEOUT_EN defined: 16-bit counter increments each BUS cycle without ack_i/err_i; when it reaches TIMEOUT_CYCLES, abort: drop cyc_o/stb_o, go RESP with rsp_err = 1, rsp_dat = 0. Ack on the same edge as expiry takes priority over timeout.
- Undefined: no counter; BUS waits indefinitely; TIMEOUT_CYCLES ignored.

## Structure
- Shared package wb_pkg: FSM state encoding (IDLE=0, BUS=1, RESP=2), default widths, timeout counter width constant.
- One sub-module: wb_timeout_cnt (clear, enable, expired output), instantiated only under WB_CMD_MASTER_TIMEOUT_EN.

## Test plan
- Write then read vs. 16-word wb RAM: write 0xDEADBEEF to 0x8, sel 4'hF -> rsp_err 0, rsp_dat 0; read 0x8 -> rsp_dat 0xDEADBEEF, rsp_valid in cycle 3 after accept.
- Byte write sel 4'b0010, dat 0x0000AA00 to 0x8 -> later read returns 0xDEADAAEF.
- err_i and ack_i asserted together on read -> rsp_err 1, rsp_dat 0, cyc_o low next cycle.
- Timeout build, TIMEOUT_CYCLES = 4, slave never acks -> stb_o high 4 cycles, then rsp_err 1; non-timeout build stays in BUS 1000 cycles.
- rsp_ready held low 10 cycles -> rsp_valid/rsp_dat stable, cmd_ready 0, cyc_o 0 throughout.
- rst pulsed while stb_o high -> cyc_o/stb_o low same cycle, no rsp_valid; next command completes normally.
